// File: rtl/dpc_mean_replace.sv
// dpc_mean_replace
//   Sits downstream of the pipelined neighbour-mean divider in the dead-pixel
//   corrector. The centre pixel and its flags travel through a delay line that
//   matches the divider pipeline. When they meet the quotient, a dead pixel is
//   replaced by the saturated mean, or by the last good pixel if no good
//   neighbours existed. Per-frame counts of corrected and unfixable pixels are
//   published at each start of frame after the first.
//
// Ports
//   clock, aclr      rising-edge clock, asynchronous active-high reset
//   clken            global enable shared with the divider; low freezes all state
//   in_valid/in_sof  centre pixel valid / first pixel of frame
//   in_pixel         centre pixel
//   in_dead          centre pixel flagged dead
//   in_cnt           good-neighbour count (the divider's denominator)
//   div_quotient     divider quotient, aligned with delay stage DIV_LATENCY-1
//   out_valid/out_sof, out_pixel, out_corrected, out_unfixable
//                    corrected pixel stream, latency DIV_LATENCY+1 enabled clocks
//   stat_valid       one enabled-cycle pulse when stat_corr/stat_unfix update
//   stat_corr/stat_unfix  previous-frame corrected / unfixable counts
module dpc_mean_replace #(
  parameter int DATA_W      = 14,
  parameter int NUM_W       = 18,
  parameter int CNT_W       = 4,
  parameter int DIV_LATENCY = 16,
  parameter int STAT_W      = 16
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              clken,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              in_dead,
  input  logic [CNT_W-1:0]  in_cnt,
  input  logic [NUM_W-1:0]  div_quotient,
  output logic              out_valid,
  output logic              out_sof,
  output logic [DATA_W-1:0] out_pixel,
  output logic              out_corrected,
  output logic              out_unfixable,
  output logic              stat_valid,
  output logic [STAT_W-1:0] stat_corr,
  output logic [STAT_W-1:0] stat_unfix
);

  // Width wide enough to compare the quotient against the pixel maximum
  // regardless of which of the two is wider.
  localparam int MAXW = (NUM_W > DATA_W) ? NUM_W : DATA_W;

  typedef struct packed {
    logic              valid;
    logic              sof;
    logic              dead;
    logic              cnt_zero;
    logic [DATA_W-1:0] pixel;
  } stage_t;

  typedef enum logic {IDLE, ACTIVE} state_t;

  stage_t            r_dl [DIV_LATENCY];
  stage_t            w_in;
  stage_t            w_al;
  logic [MAXW-1:0]   w_q_ext;
  logic [MAXW-1:0]   w_pix_max_ext;
  logic [DATA_W-1:0] w_mean;
  logic [DATA_W-1:0] w_pix_next;
  logic              w_corr;
  logic              w_unfix;
  logic              w_sof_al;

  logic              r_out_valid;
  logic              r_out_sof;
  logic [DATA_W-1:0] r_out_pixel;
  logic              r_out_corrected;
  logic              r_out_unfixable;
  logic [DATA_W-1:0] r_hold_pix;

  state_t            r_state;
  logic [STAT_W-1:0] r_cnt_corr;
  logic [STAT_W-1:0] r_cnt_unfix;
  logic              r_stat_valid;
  logic [STAT_W-1:0] r_stat_corr;
  logic [STAT_W-1:0] r_stat_unfix;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic inc);
    return (inc && (v != {STAT_W{1'b1}})) ? v + STAT_W'(1) : v;
  endfunction

  assign w_in.valid    = in_valid;
  assign w_in.sof      = in_sof;
  assign w_in.dead     = in_dead;
  assign w_in.cnt_zero = (in_cnt == '0);
  assign w_in.pixel    = in_pixel;

  // Delay line: stage DIV_LATENCY-1 lines up with div_quotient.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int k = 0; k < DIV_LATENCY; k++) r_dl[k] <= '0;
    end else if (clken) begin
      r_dl[0] <= w_in;
      for (int k = 1; k < DIV_LATENCY; k++) r_dl[k] <= r_dl[k-1];
    end
  end

  assign w_al          = r_dl[DIV_LATENCY-1];
  assign w_q_ext       = MAXW'(div_quotient);
  assign w_pix_max_ext = MAXW'({DATA_W{1'b1}});
  assign w_mean        = (w_q_ext > w_pix_max_ext) ? {DATA_W{1'b1}} : w_q_ext[DATA_W-1:0];
  assign w_sof_al      = w_al.valid & w_al.sof;

  // Substitution; out_pixel keeps its last value on invalid slots.
  always_comb begin
    w_pix_next = r_out_pixel;
    w_corr     = 1'b0;
    w_unfix    = 1'b0;
    if (w_al.valid) begin
      if (!w_al.dead) begin
        w_pix_next = w_al.pixel;
      end else if (!w_al.cnt_zero) begin
        w_pix_next = w_mean;
        w_corr     = 1'b1;
      end else begin
        // No good neighbours: the quotient is meaningless, reuse last good pixel.
        w_pix_next = r_hold_pix;
        w_unfix    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_out_valid     <= 1'b0;
      r_out_sof       <= 1'b0;
      r_out_pixel     <= '0;
      r_out_corrected <= 1'b0;
      r_out_unfixable <= 1'b0;
      r_hold_pix      <= '0;
    end else if (clken) begin
      r_out_valid     <= w_al.valid;
      r_out_sof       <= w_sof_al;
      r_out_pixel     <= w_pix_next;
      r_out_corrected <= w_corr;
      r_out_unfixable <= w_unfix;
      // Held across frames on purpose: a frame may open with an unfixable pixel.
      if (w_al.valid && !w_al.dead) r_hold_pix <= w_al.pixel;
    end
  end

  // Statistics: the first sof after reset only arms counting; each later sof
  // publishes the finished frame and restarts the counters with the sof
  // pixel's own flags.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_state      <= IDLE;
      r_cnt_corr   <= '0;
      r_cnt_unfix  <= '0;
      r_stat_valid <= 1'b0;
      r_stat_corr  <= '0;
      r_stat_unfix <= '0;
    end else if (clken) begin
      r_stat_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_sof_al) begin
            r_state     <= ACTIVE;
            r_cnt_corr  <= STAT_W'(w_corr);
            r_cnt_unfix <= STAT_W'(w_unfix);
          end
        end
        ACTIVE: begin
          if (w_sof_al) begin
            r_stat_valid <= 1'b1;
            r_stat_corr  <= r_cnt_corr;
            r_stat_unfix <= r_cnt_unfix;
            r_cnt_corr   <= STAT_W'(w_corr);
            r_cnt_unfix  <= STAT_W'(w_unfix);
          end else begin
            r_cnt_corr   <= sat_inc(r_cnt_corr, w_corr);
            r_cnt_unfix  <= sat_inc(r_cnt_unfix, w_unfix);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid     = r_out_valid;
  assign out_sof       = r_out_sof;
  assign out_pixel     = r_out_pixel;
  assign out_corrected = r_out_corrected;
  assign out_unfixable = r_out_unfixable;
  assign stat_valid    = r_stat_valid;
  assign stat_corr     = r_stat_corr;
  assign stat_unfix    = r_stat_unfix;

endmodule

// File: tb/tb_dpc_mean_replace.sv
// tb_dpc_mean_replace
//   Directed bench for dpc_mean_replace with a behavioural pipelined divider
//   (numer/denom, DIV_LATENCY enabled stages) feeding div_quotient.
module tb_dpc_mean_replace;

  localparam int DATA_W = 14;
  localparam int NUM_W  = 18;
  localparam int CNT_W  = 4;
  localparam int L      = 16;
  localparam int STAT_W = 16;
  localparam int MAXS   = 32;

  logic              clock;
  logic              aclr;
  logic              clken;
  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_pixel;
  logic              in_dead;
  logic [CNT_W-1:0]  in_cnt;
  logic [NUM_W-1:0]  div_quotient;
  logic              out_valid;
  logic              out_sof;
  logic [DATA_W-1:0] out_pixel;
  logic              out_corrected;
  logic              out_unfixable;
  logic              stat_valid;
  logic [STAT_W-1:0] stat_corr;
  logic [STAT_W-1:0] stat_unfix;

  logic [NUM_W-1:0]  tb_numer;
  logic [NUM_W-1:0]  q_pipe [L];
  logic              force_q_en;
  logic [NUM_W-1:0]  force_q;

  int total = 0;
  int bad   = 0;

  // stimulus sequence and expectations
  int                n_seq;
  bit                seq_sof  [MAXS];
  bit                seq_dead [MAXS];
  logic [DATA_W-1:0] seq_pix  [MAXS];
  logic [CNT_W-1:0]  seq_cnt  [MAXS];
  logic [NUM_W-1:0]  seq_num  [MAXS];
  int                exp_pix  [MAXS];
  bit                exp_corr [MAXS];
  bit                exp_unf  [MAXS];
  int                model_hold;

  // captured outputs
  int                n_cap;
  int                stray;
  int                cap_pix  [MAXS];
  bit                cap_corr [MAXS];
  bit                cap_unf  [MAXS];
  bit                cap_sof  [MAXS];
  bit                cap_sv   [MAXS];
  int                cap_sc   [MAXS];
  int                cap_su   [MAXS];

  dpc_mean_replace #(
    .DATA_W(DATA_W), .NUM_W(NUM_W), .CNT_W(CNT_W), .DIV_LATENCY(L), .STAT_W(STAT_W)
  ) dut (
    .clock(clock), .aclr(aclr), .clken(clken),
    .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel), .in_dead(in_dead),
    .in_cnt(in_cnt), .div_quotient(div_quotient),
    .out_valid(out_valid), .out_sof(out_sof), .out_pixel(out_pixel),
    .out_corrected(out_corrected), .out_unfixable(out_unfixable),
    .stat_valid(stat_valid), .stat_corr(stat_corr), .stat_unfix(stat_unfix)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural divider model, gated by the shared enable.
  always @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int k = 0; k < L; k++) q_pipe[k] <= '0;
    end else if (clken) begin
      for (int k = L-1; k > 0; k--) q_pipe[k] <= q_pipe[k-1];
      q_pipe[0] <= (in_cnt == '0) ? {NUM_W{1'b1}} : tb_numer / NUM_W'(in_cnt);
    end
  end
  assign div_quotient = force_q_en ? force_q : q_pipe[L-1];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; in_dead = 1'b0; in_cnt = '0; tb_numer = '0;
  endtask

  task automatic clear_seq();
    n_seq = 0;
  endtask

  // Append a pixel and derive its expected output from the reference rules.
  task automatic add_px(input bit sof, input bit dead, input int pix, input int cnt, input int num);
    int q;
    seq_sof[n_seq]  = sof;
    seq_dead[n_seq] = dead;
    seq_pix[n_seq]  = DATA_W'(pix);
    seq_cnt[n_seq]  = CNT_W'(cnt);
    seq_num[n_seq]  = NUM_W'(num);
    exp_corr[n_seq] = 1'b0;
    exp_unf[n_seq]  = 1'b0;
    if (!dead) begin
      exp_pix[n_seq] = pix;
      model_hold     = pix;
    end else if (cnt != 0) begin
      q = num / cnt;
      exp_pix[n_seq]  = (q > 16383) ? 16383 : q;
      exp_corr[n_seq] = 1'b1;
    end else begin
      exp_pix[n_seq] = model_hold;
      exp_unf[n_seq] = 1'b1;
    end
    n_seq++;
  endtask

  // Drive the sequence back to back, optionally dropping clken on 5 random
  // cycles; record every output produced on an enabled edge.
  task automatic run_seq(input bit gated);
    bit drop [64];
    int sent;
    int k;
    int c;
    bit en;
    for (int i = 0; i < 64; i++) drop[i] = 1'b0;
    if (gated) begin
      k = 0;
      while (k < 5) begin
        c = int'($urandom_range(3, 28));
        if (!drop[c]) begin drop[c] = 1'b1; k++; end
      end
    end
    sent = 0; n_cap = 0; stray = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      en = !drop[cyc];
      clken = en;
      if (!en) begin
        // garbage that a frozen pipeline must not absorb
        in_valid = 1'b1; in_sof = 1'b1; in_pixel = '1; in_dead = 1'b0; in_cnt = 4'd1; tb_numer = 18'd5;
      end else if (sent < n_seq) begin
        in_valid = 1'b1; in_sof = seq_sof[sent]; in_pixel = seq_pix[sent];
        in_dead = seq_dead[sent]; in_cnt = seq_cnt[sent]; tb_numer = seq_num[sent];
      end else begin
        idle_inputs();
      end
      tick();
      if (en && sent < n_seq) sent++;
      if (en) begin
        if (out_valid) begin
          if (n_cap < MAXS) begin
            cap_pix[n_cap]  = int'(out_pixel);
            cap_corr[n_cap] = out_corrected;
            cap_unf[n_cap]  = out_unfixable;
            cap_sof[n_cap]  = out_sof;
            cap_sv[n_cap]   = stat_valid;
            cap_sc[n_cap]   = int'(stat_corr);
            cap_su[n_cap]   = int'(stat_unfix);
          end
          n_cap++;
        end else if (stat_valid) begin
          stray++;
        end
      end
    end
    clken = 1'b1;
    idle_inputs();
  endtask

  task automatic apply_reset();
    aclr = 1'b1;
    tick(); tick();
    aclr = 1'b0;
    model_hold = 0;
    tick();
  endtask

  task automatic test_reset();
    int n;
    aclr = 1'b1; clken = 1'b1;
    in_valid = 1'b1; in_sof = 1'b1; in_pixel = 14'h1555; in_dead = 1'b1; in_cnt = 4'd3; tb_numer = 18'd90;
    repeat (4) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    total++; if (out_pixel !== '0) begin bad++; $display("FAIL rst_pixel got=%h want=0", out_pixel); end
    total++; if ({out_sof, out_corrected, out_unfixable, stat_valid} !== 4'b0) begin
      bad++; $display("FAIL rst_flags got=%b want=0000", {out_sof, out_corrected, out_unfixable, stat_valid}); end
    total++; if ({stat_corr, stat_unfix} !== '0) begin
      bad++; $display("FAIL rst_stats got=%h/%h want=0/0", stat_corr, stat_unfix); end
    idle_inputs();
    aclr = 1'b0;
    model_hold = 0;
    tick();
    in_valid = 1'b1; in_pixel = 14'h123; in_dead = 1'b0; in_cnt = 4'd8; tb_numer = 18'd0;
    tick();
    idle_inputs();
    n = 1;
    while (!out_valid && n < 40) begin tick(); n++; end
    total++; if (n !== L + 1) begin bad++; $display("FAIL latency got=%0d want=%0d", n, L + 1); end
    total++; if (out_pixel !== 14'h123) begin bad++; $display("FAIL lat_pixel got=%h want=123", out_pixel); end
    total++; if (out_corrected !== 1'b0) begin bad++; $display("FAIL lat_corr got=%b want=0", out_corrected); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_single got=%b want=0", out_valid); end
    total++; if (out_pixel !== 14'h123) begin bad++; $display("FAIL lat_hold got=%h want=123", out_pixel); end
    model_hold = 'h123;
    $display("test_reset: latency=%0d pixel=%h", n, out_pixel);
    repeat (3) tick();
  endtask

  task automatic test_mean();
    clear_seq();
    add_px(0, 1, 0, 8, 800);
    add_px(0, 1, 0, 1, 16383);
    add_px(0, 1, 0, 1, 16384);
    run_seq(0);
    total++; if (n_cap !== 3) begin bad++; $display("FAIL mean_count got=%0d want=3", n_cap); end
    for (int i = 0; i < 3 && i < n_cap; i++) begin
      total++;
      if (cap_pix[i] !== exp_pix[i] || cap_corr[i] !== 1'b1 || cap_unf[i] !== 1'b0) begin
        bad++; $display("FAIL mean_px%0d got=%h c=%b u=%b want=%h c=1 u=0", i, cap_pix[i], cap_corr[i], cap_unf[i], exp_pix[i]);
      end
      $display("test_mean: px%0d out=%h corrected=%b", i, cap_pix[i], cap_corr[i]);
    end
    force_q = 18'h3FFFF; force_q_en = 1'b1;
    clear_seq();
    add_px(0, 1, 0, 8, 800);
    run_seq(0);
    force_q_en = 1'b0;
    total++; if (n_cap !== 1 || cap_pix[0] !== 'h3FFF || cap_corr[0] !== 1'b1) begin
      bad++; $display("FAIL mean_forced got=n%0d %h c=%b want=n1 3fff c=1", n_cap, cap_pix[0], cap_corr[0]);
    end
    $display("test_mean: forced quotient out=%h", cap_pix[0]);
  endtask

  task automatic test_unfixable();
    clear_seq();
    add_px(0, 0, 'h200, 8, 100);
    add_px(0, 1, 0, 0, 999);
    add_px(0, 1, 0, 0, 5);
    run_seq(0);
    total++; if (n_cap !== 3) begin bad++; $display("FAIL unf_count got=%0d want=3", n_cap); end
    for (int i = 0; i < 3 && i < n_cap; i++) begin
      total++;
      if (cap_pix[i] !== exp_pix[i] || cap_corr[i] !== exp_corr[i] || cap_unf[i] !== exp_unf[i]) begin
        bad++; $display("FAIL unf_px%0d got=%h c=%b u=%b want=%h c=%b u=%b", i, cap_pix[i], cap_corr[i], cap_unf[i],
                        exp_pix[i], exp_corr[i], exp_unf[i]);
      end
      $display("test_unfixable: px%0d out=%h unfixable=%b", i, cap_pix[i], cap_unf[i]);
    end
  endtask

  task automatic test_clken_gating();
    for (int run = 0; run < 2; run++) begin
      clear_seq();
      add_px(0, 0, 'h010, 8, 0);
      add_px(0, 1, 0, 4, 100);
      add_px(0, 0, 'h3FF, 8, 0);
      add_px(0, 1, 0, 0, 77);
      add_px(0, 1, 0, 2, 40000);
      add_px(0, 0, 'h2AB, 8, 0);
      add_px(0, 1, 0, 1, 7);
      add_px(0, 1, 0, 0, 3);
      run_seq(run == 1);
      total++; if (n_cap !== n_seq) begin bad++; $display("FAIL gate%0d_count got=%0d want=%0d", run, n_cap, n_seq); end
      for (int i = 0; i < n_seq && i < n_cap; i++) begin
        total++;
        if (cap_pix[i] !== exp_pix[i] || cap_corr[i] !== exp_corr[i] || cap_unf[i] !== exp_unf[i]) begin
          bad++; $display("FAIL gate%0d_px%0d got=%h c=%b u=%b want=%h c=%b u=%b", run, i, cap_pix[i], cap_corr[i],
                          cap_unf[i], exp_pix[i], exp_corr[i], exp_unf[i]);
        end
      end
      $display("test_clken_gating: gated=%0d outputs=%0d", run, n_cap);
    end
  endtask

  task automatic test_frame_stats();
    bit want_sv [10];
    apply_reset();
    clear_seq();
    add_px(1, 0, 'h050, 8, 0);     // frame1 sof
    add_px(0, 1, 0, 2, 20);        // corrected
    add_px(0, 1, 0, 3, 30);        // corrected
    add_px(0, 0, 'h060, 8, 0);
    add_px(0, 1, 0, 0, 9);         // unfixable
    add_px(0, 1, 0, 4, 40);        // corrected
    add_px(1, 1, 0, 4, 400);       // frame2 sof, itself corrected
    add_px(0, 1, 0, 0, 1);         // unfixable
    add_px(1, 0, 'h070, 8, 0);     // frame3 sof
    add_px(0, 0, 'h071, 8, 0);
    for (int i = 0; i < 10; i++) want_sv[i] = (i == 6 || i == 8);
    run_seq(0);
    total++; if (n_cap !== 10) begin bad++; $display("FAIL stat_count got=%0d want=10", n_cap); end
    total++; if (stray !== 0) begin bad++; $display("FAIL stat_stray got=%0d want=0", stray); end
    for (int i = 0; i < 10 && i < n_cap; i++) begin
      total++;
      if (cap_sv[i] !== want_sv[i] || cap_sof[i] !== seq_sof[i] || cap_pix[i] !== exp_pix[i]) begin
        bad++; $display("FAIL stat_px%0d got sv=%b sof=%b pix=%h want sv=%b sof=%b pix=%h", i, cap_sv[i], cap_sof[i],
                        cap_pix[i], want_sv[i], seq_sof[i], exp_pix[i]);
      end
    end
    total++; if (cap_sc[0] !== 0 || cap_su[0] !== 0) begin
      bad++; $display("FAIL stat_f1 got=%0d/%0d want=0/0", cap_sc[0], cap_su[0]); end
    total++; if (cap_sc[6] !== 3 || cap_su[6] !== 1) begin
      bad++; $display("FAIL stat_f2 got=%0d/%0d want=3/1", cap_sc[6], cap_su[6]); end
    total++; if (cap_sc[7] !== 3 || cap_su[7] !== 1) begin
      bad++; $display("FAIL stat_hold got=%0d/%0d want=3/1", cap_sc[7], cap_su[7]); end
    total++; if (cap_sc[8] !== 1 || cap_su[8] !== 1) begin
      bad++; $display("FAIL stat_f3 got=%0d/%0d want=1/1", cap_sc[8], cap_su[8]); end
    $display("test_frame_stats: f2 corr=%0d unfix=%0d f3 corr=%0d unfix=%0d", cap_sc[6], cap_su[6], cap_sc[8], cap_su[8]);
  endtask

  task automatic test_aclr_midframe();
    int seen;
    int n;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_sof = 1'b0; in_pixel = DATA_W'(256 + i); in_dead = i[0]; in_cnt = 4'd2; tb_numer = 18'd50;
      tick();
    end
    idle_inputs();
    aclr = 1'b1;
    #1;
    total++; if ({out_valid, stat_corr, stat_unfix} !== '0) begin
      bad++; $display("FAIL aclr_async got=%b/%0d/%0d want=0/0/0", out_valid, stat_corr, stat_unfix); end
    tick();
    aclr = 1'b0;
    model_hold = 0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL aclr_flush got=%0d want=0", seen); end
    in_valid = 1'b1; in_sof = 1'b1; in_pixel = 14'h0AA; in_dead = 1'b0; in_cnt = 4'd8;
    tick();
    idle_inputs();
    n = 1;
    while (!out_valid && n < 40) begin tick(); n++; end
    total++; if (n !== L + 1) begin bad++; $display("FAIL aclr_lat got=%0d want=%0d", n, L + 1); end
    total++; if (out_sof !== 1'b1 || out_pixel !== 14'h0AA) begin
      bad++; $display("FAIL aclr_px got sof=%b pix=%h want sof=1 pix=0aa", out_sof, out_pixel); end
    total++; if (stat_valid !== 1'b0) begin bad++; $display("FAIL aclr_idle got=%b want=0", stat_valid); end
    $display("test_aclr_midframe: flushed=%0d latency=%0d stat_valid=%b", seen, n, stat_valid);
    repeat (2) tick();
  endtask

  initial begin
    force_q_en = 1'b0;
    force_q    = '0;
    model_hold = 0;
    idle_inputs();
    aclr  = 1'b1;
    clken = 1'b1;
    test_reset();
    test_mean();
    test_unfixable();
    test_clken_gating();
    test_frame_stats();
    test_aclr_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
